alu8_flags: RTL and testbench
=============================

Name: alu8_flags

Overview:
- 8-bit registered ALU: add and subtract with carry/borrow-in, bitwise AND and OR.
- Produces four status flags: carry/borrow, even parity, zero, signed overflow.
- Sits in the datapath as a single-cycle-latency arithmetic unit.
- All outputs are registered on one clock.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- liczbaA  input  8  operand A (unsigned / two's complement)
- liczbaB  input  8  operand B (unsigned / two's complement)
- wybor  input  2  operation select
- bitP  input  1  carry-in for add, borrow-in for subtract; ignored for logic ops
- wynik  output  8  registered result
- C  output  1  registered carry-out (add) or borrow-out (subtract)
- EVEN  output  1  registered even-parity flag of wynik
- Z  output  1  registered zero flag of wynik
- OV  output  1  registered signed-overflow flag

Behaviour:
- Clocking: one clock (clk); reset rst is synchronous and active-high. rst sampled high at a rising edge forces wynik=0x00, C=0, EVEN=0, Z=0, OV=0 on that edge. rst has priority over any operation.
- Latency: inputs sampled at rising edge N appear on all outputs after edge N; exactly 1 cycle. No handshake; a new operation is accepted every cycle.
- wybor=00 ADD:
  - sum9 = A + B + bitP, computed 9 bits wide.
  - wynik = sum9[7:0]; C = sum9[8].
  - OV = 1 when A[7]==B[7] and wynik[7]!=A[7].
- wybor=01 SUB:
  - diff9 = {0,A} - {0,B} - bitP, computed 9 bits wide.
  - wynik = diff9[7:0]; C = 1 (borrow) when A < B + bitP, unsigned.
  - OV = 1 when A[7]!=B[7] and wynik[7]!=A[7].
- wybor=10 AND: wynik = A & B; C=0; OV=0.
- wybor=11 OR: wynik = A | B; C=0; OV=0.
- Flags for all ops, computed from the final wynik value:
  - Z = 1 when wynik == 0x00.
  - EVEN = 1 when wynik contains an even number of 1 bits; 0x00 counts as even.
- Boundaries:
  - 0xFF + 0x00 + bitP=1 wraps to wynik=0x00 with C=1, Z=1.
  - 0x00 - 0x00 - bitP=1 gives wynik=0xFF with C=1.
  - bitP has no effect on AND or OR.
- Reset mid-stream: the cycle in which rst is high discards that cycle's operation. Operation resumes on the first edge with rst low.

Optional Feature:
- Macro: ALU_SAT_EN.
- When defined: ADD and SUB saturate on signed overflow. wynik becomes 0x7F when A[7]=0, or 0x80 when A[7]=1. OV is still reported as 1. C is computed from the unsaturated 9-bit result. Z and EVEN are computed from the saturated wynik.
- When not defined: wrap-around arithmetic exactly as in Behaviour. No saturation logic is synthesised.

Test Plan:
- Reset: hold rst=1 for 2 edges with any inputs -> wynik=0x00, C=0, EVEN=0, Z=0, OV=0. Release, then ADD 0x05+0x03 -> 0x08 one cycle later.
- Small operands, bitP=0, A=0x05, B=0x03:
  - ADD -> wynik 0x08, C0, OV0, Z0, EVEN0.
  - SUB -> 0x02, C0, OV0, EVEN0.
  - AND -> 0x01, EVEN0.
  - OR -> 0x07, EVEN0.
- Negative operands, A=0x85, B=0x87:
  - ADD -> 0x0C, C1, OV1, EVEN1 (without ALU_SAT_EN; with it -> 0x80, OV1).
  - SUB -> 0xFE, C1, OV0, EVEN0.
  - AND -> 0x85.
  - OR -> 0x87.
- Carry and no-carry cases:
  - ADD 0xFF+0x81 -> 0x80, C1, OV0, EVEN0.
  - ADD 0x01+0x81 -> 0x82, C0, OV0, EVEN1.
  - AND 0x01&0x81 -> 0x01.
- Carry-in, bitP=1, A=0x05, B=0x03:
  - ADD -> 0x09, EVEN1.
  - SUB -> 0x01, C0.
  - AND -> 0x01 (bitP ignored).
- Zero and wrap:
  - SUB 0x05-0x05 -> 0x00, Z1, EVEN1, C0.
  - ADD 0xFF+0x00+bitP=1 -> 0x00, C1, Z1.
  - SUB 0x00-0x00-bitP=1 -> 0xFF, C1, EVEN1.

Source files
------------

// File: rtl/alu8_flags.sv
// 8-bit registered ALU (add/sub with carry-in, AND, OR) with carry, parity, zero and overflow flags.
// Optional macro ALU_SAT_EN: ADD/SUB saturate to 0x7F/0x80 on signed overflow.
module alu8_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] liczbaA,
    input  logic [7:0] liczbaB,
    input  logic [1:0] wybor,
    input  logic       bitP,
    output logic [7:0] wynik,
    output logic       C,
    output logic       EVEN,
    output logic       Z,
    output logic       OV
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] wynik_d, wynik_q;
    logic       c_d, c_q;
    logic       ov_d, ov_q;
    logic       even_d, even_q;
    logic       z_d, z_q;

    assign sum9  = {1'b0, liczbaA} + {1'b0, liczbaB} + {8'b0, bitP};
    // A borrow leaves bit 8 set, since the true difference stays within [-256, 255].
    assign diff9 = {1'b0, liczbaA} - {1'b0, liczbaB} - {8'b0, bitP};

    always_comb begin
        wynik_d = 8'h00;
        c_d     = 1'b0;
        ov_d    = 1'b0;
        case (op_e'(wybor))
            OP_ADD: begin
                wynik_d = sum9[7:0];
                c_d     = sum9[8];
                ov_d    = (liczbaA[7] == liczbaB[7]) && (sum9[7] != liczbaA[7]);
            end
            OP_SUB: begin
                wynik_d = diff9[7:0];
                c_d     = diff9[8];
                ov_d    = (liczbaA[7] != liczbaB[7]) && (diff9[7] != liczbaA[7]);
            end
            OP_AND: wynik_d = liczbaA & liczbaB;
            OP_OR:  wynik_d = liczbaA | liczbaB;
            default: wynik_d = 8'h00;
        endcase
`ifdef ALU_SAT_EN
        // Logic ops never raise ov_d, so only arithmetic results clamp; carry stays unsaturated.
        if (ov_d) begin
            wynik_d = liczbaA[7] ? 8'h80 : 8'h7F;
        end
`endif
        even_d = ~(^wynik_d);
        z_d    = (wynik_d == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wynik_q <= 8'h00;
            c_q     <= 1'b0;
            ov_q    <= 1'b0;
            even_q  <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            wynik_q <= wynik_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            even_q  <= even_d;
            z_q     <= z_d;
        end
    end

    assign wynik = wynik_q;
    assign C     = c_q;
    assign EVEN  = even_q;
    assign Z     = z_q;
    assign OV    = ov_q;

endmodule

// File: tb/tb_alu8_flags.sv
// Self-checking bench for alu8_flags: directed vector table, reset sequences and
// randomized operations compared against an arithmetic reference model.
module tb_alu8_flags;

    logic       clk;
    logic       rst;
    logic [7:0] liczbaA;
    logic [7:0] liczbaB;
    logic [1:0] wybor;
    logic       bitP;
    logic [7:0] wynik;
    logic       C;
    logic       EVEN;
    logic       Z;
    logic       OV;

    int checkCount;
    int failCount;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       cin;
        logic [7:0] expRes;
        logic       expC;
        logic       expEven;
        logic       expZ;
        logic       expOv;
    } vec_t;

    vec_t vecs[18];

    alu8_flags dut (
        .clk     (clk),
        .rst     (rst),
        .liczbaA (liczbaA),
        .liczbaB (liczbaB),
        .wybor   (wybor),
        .bitP    (bitP),
        .wynik   (wynik),
        .C       (C),
        .EVEN    (EVEN),
        .Z       (Z),
        .OV      (OV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model works on plain integers: unsigned sums for carry/borrow,
    // signed sums for overflow, population count for parity.
    function automatic void refModel(input logic [7:0] a, input logic [7:0] b,
                                     input logic [1:0] op, input logic cin,
                                     output logic [7:0] res, output logic c,
                                     output logic ev, output logic z, output logic ov);
        int ua, ub, sa, sb, ci, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(cin);
        c  = 1'b0;
        ov = 1'b0;
        res = 8'h00;
        case (op)
            2'd0: begin
                u = ua + ub + ci;
                s = sa + sb + ci;
                res = u[7:0];
                c = (u > 255);
                ov = (s > 127) || (s < -128);
            end
            2'd1: begin
                u = ua - ub - ci;
                s = sa - sb - ci;
                res = u[7:0];
                c = (ua < ub + ci);
                ov = (s > 127) || (s < -128);
            end
            2'd2: res = a & b;
            default: res = a | b;
        endcase
`ifdef ALU_SAT_EN
        if (ov) res = (s > 127) ? 8'h7F : 8'h80;
`endif
        ev = ($countones(res) % 2) == 0;
        z  = (res == 8'h00);
    endfunction

    task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] op, input logic cin);
        rst = r;
        liczbaA = a;
        liczbaB = b;
        wybor = op;
        bitP = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expRes, input logic expC,
                               input logic expEven, input logic expZ, input logic expOv);
        checkCount += 5;
        if (wynik !== expRes) begin
            failCount++;
            $display("[TB] FAIL %s wynik: got %02h expected %02h", name, wynik, expRes);
        end
        if (C !== expC) begin
            failCount++;
            $display("[TB] FAIL %s C: got %b expected %b", name, C, expC);
        end
        if (EVEN !== expEven) begin
            failCount++;
            $display("[TB] FAIL %s EVEN: got %b expected %b", name, EVEN, expEven);
        end
        if (Z !== expZ) begin
            failCount++;
            $display("[TB] FAIL %s Z: got %b expected %b", name, Z, expZ);
        end
        if (OV !== expOv) begin
            failCount++;
            $display("[TB] FAIL %s OV: got %b expected %b", name, OV, expOv);
        end
    endtask

    initial begin
        logic [7:0] ra, rb, mRes;
        logic [1:0] rop;
        logic       rcin, mC, mEv, mZ, mOv;

        checkCount = 0;
        failCount  = 0;

        vecs = '{
            '{8'h05, 8'h03, 2'd0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd2, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd3, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h85, 8'h87, 2'd0, 1'b0, 8'h0C, 1'b1, 1'b1, 1'b0, 1'b1},
            '{8'h85, 8'h87, 2'd1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'h85, 8'h87, 2'd2, 1'b0, 8'h85, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h85, 8'h87, 2'd3, 1'b0, 8'h87, 1'b0, 1'b1, 1'b0, 1'b0},
            '{8'hFF, 8'h81, 2'd0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'h01, 8'h81, 2'd0, 1'b0, 8'h82, 1'b0, 1'b1, 1'b0, 1'b0},
            '{8'h01, 8'h81, 2'd2, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd0, 1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'h05, 8'h05, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0},
            '{8'hFF, 8'h00, 2'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0},
            '{8'h00, 8'h00, 2'd1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'h05, 8'h03, 2'd3, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0}
        };
`ifdef ALU_SAT_EN
        vecs[4].expRes  = 8'h80;
        vecs[4].expEven = 1'b0;
`endif

        // Reset held for two edges with a live ADD on the inputs
        rst = 1'b1; liczbaA = 8'h00; liczbaB = 8'h00; wybor = 2'd0; bitP = 1'b0;
        applyStimulus(1'b1, 8'hFF, 8'h01, 2'd0, 1'b1);
        checkOutput("reset_edge1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h85, 8'h87, 2'd0, 1'b0);
        checkOutput("reset_edge2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h05, 8'h03, 2'd0, 1'b0);
        checkOutput("after_reset_add", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRes, vecs[i].expC,
                        vecs[i].expEven, vecs[i].expZ, vecs[i].expOv);
        end

        // Mid-stream reset discards the operation presented in that cycle
        applyStimulus(1'b0, 8'hFF, 8'h81, 2'd0, 1'b0);
        checkOutput("pre_midreset", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h05, 8'h03, 2'd3, 1'b0);
        checkOutput("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd1, 1'b1);
        checkOutput("post_midreset", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rop  = 2'($urandom_range(0, 3));
            rcin = 1'($urandom);
            refModel(ra, rb, rop, rcin, mRes, mC, mEv, mZ, mOv);
            applyStimulus(1'b0, ra, rb, rop, rcin);
            checkOutput($sformatf("rand%0d op%0d %02h,%02h,%b", i, rop, ra, rb, rcin),
                        mRes, mC, mEv, mZ, mOv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
